// File: rtl/aes_pkg.sv
// aes_pkg: AES constants, FSM state type and GF(2^8) helpers
// shared by the encrypt and decrypt datapaths.
package aes_pkg;

  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // Byte s[r][c] lives at bits 127-8*(4c+r); row r rotates right by r.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r)&3)+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {
      gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3),
      gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3),
      gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3),
      gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3)
    };
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// inv_sbox: combinational AES inverse S-box lookup,
// 256 entries packed row-major from index 0.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign y = INV_SBOX[a];

endmodule

// File: rtl/aes128_inv_cipher.sv
// aes128_inv_cipher: iterative AES-128 inverse cipher, one round per
// cycle, round keys fetched from an external store by descending index.
module aes128_inv_cipher
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out
);

  state_e       st, st_nx;
  logic [3:0]   cnt, cnt_nx;
  logic [127:0] s, s_nx;
  logic [127:0] isr, isb, ark, imc;

  assign isr = inv_shift_rows(s);

  for (genvar i = 0; i < 16; i++) begin : g_sbox
    inv_sbox u_sbox (
      .a (isr[8*i +: 8]),
      .y (isb[8*i +: 8])
    );
  end

  assign ark = isb ^ rk;

  for (genvar i = 0; i < 4; i++) begin : g_imc
    assign imc[32*i +: 32] = inv_mix_col(ark[32*i +: 32]);
  end

  assign data_out = s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= IDLE;
      cnt <= 4'd0;
      s   <= '0;
    end else begin
      st  <= st_nx;
      cnt <= cnt_nx;
      s   <= s_nx;
    end
  end

  // Outside ROUND the key store stays addressed at the last round key.
  always_comb begin
    st_nx     = st;
    cnt_nx    = cnt;
    s_nx      = s;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = 4'(NR);
    unique case (st)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          s_nx   = data_in ^ rk;
          cnt_nx = 4'(NR - 1);
          st_nx  = ROUND;
        end
      end
      ROUND: begin
        rk_idx = cnt;
        if (cnt != 4'd0) begin
          s_nx   = imc;
          cnt_nx = cnt - 4'd1;
        end else begin
          s_nx  = ark;
          st_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes128_inv_cipher.sv
// tb_aes128_inv_cipher: scoreboard bench with a behavioural key store
// and forward-cipher reference for round-trip vectors.
module tb_aes128_inv_cipher;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] data_in = '0;
  logic         in_ready, out_valid;
  logic [127:0] rk, data_out;
  logic [3:0]   rk_idx;

  logic [127:0] ks [0:10];
  logic [7:0]   sb [0:255];
  logic [127:0] exp_q [$];
  int           acc_q [$];
  int           cyc = 0;
  int           errs = 0;
  int           checks = 0;
  bit           prev_ov = 1'b0;

  localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign rk = (rk_idx <= 4'd10) ? ks[rk_idx] : '0;

  aes128_inv_cipher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .rk_idx    (rk_idx),
    .rk        (rk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = '0; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sb[s[127-8*(4*((c+r)&3)+r) -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127-32*c -: 32];
      o[127-32*c -: 32] = {
        gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3,
        a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3,
        a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03),
        gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02)};
    end
    return o;
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ ks[0];
    for (int r = 1; r <= 10; r++) begin
      s = sub_shift(s);
      if (r < 10) s = mix(s);
      s = s ^ ks[r];
    end
    return s;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int i = 1; i < 256; i++)
        if (gmul(8'(x), 8'(i)) == 8'h01) inv = 8'(i);
      sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3)
            ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic load_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]}
          ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++)
      ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic send(input logic [127:0] ct, input logic [127:0] pt,
                      input bit hold, output int acc);
    int n;
    n = 0;
    data_in  = ct;
    in_valid = 1'b1;
    exp_q.push_back(pt);
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errs++; checks++;
      $display("FAIL accept_timeout: in_ready=%0b want 1", in_ready);
    end
    acc = cyc + 1;
    acc_q.push_back(acc);
    @(posedge clk); #1;
    in_valid = hold;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      errs++; checks++;
      $display("FAIL drain_timeout: pending=%0d want 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) begin
          errs++; checks++;
          $display("FAIL spurious_valid: out_valid=1 want 0");
        end else begin
          chk("latency", 128'(cyc - acc_q[0]), 128'd10);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errs++; checks++;
          $display("FAIL extra_output: got %h want none", data_out);
        end else begin
          chk("data_out", data_out, exp_q.pop_front());
          if (acc_q.size() != 0) void'(acc_q.pop_front());
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin
    int a0, a1, a2;
    logic [127:0] snap, p2, p3, key, pt;

    init_sbox();
    load_key(K1);

    #3;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_data_out", data_out, 128'd0);
    chk("rst_rk_idx", 128'(rk_idx), 128'd10);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // FIPS-197 C.1 with round-key index trace
    @(negedge clk);
    chk("rk_idx_idle", 128'(rk_idx), 128'd10);
    @(posedge clk); #1;
    send(CT1, PT1, 1'b0, a0);
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk);
      chk("rk_idx_round", 128'(rk_idx), 128'(i));
    end
    @(negedge clk);
    chk("rk_idx_done", 128'(rk_idx), 128'd10);
    chk("done_valid", 128'(out_valid), 128'd1);
    drain();

    // Back-pressure with ignored input pulses
    load_key(K2);
    out_ready = 1'b0;
    send(CT2, PT2, 1'b0, a0);
    for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
    chk("bp_valid", 128'(out_valid), 128'd1);
    snap = data_out;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      in_valid = (i % 2 == 0);
      data_in  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp_hold", data_out, snap);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_idle_ready", 128'(in_ready), 128'd1);
    chk("bp_idle_valid", 128'(out_valid), 128'd0);
    @(posedge clk); #1;

    // Back-to-back, in_valid held high
    load_key(K1);
    p2 = {$urandom, $urandom, $urandom, $urandom};
    p3 = {$urandom, $urandom, $urandom, $urandom};
    send(CT1, PT1, 1'b1, a0);
    send(encrypt(p2), p2, 1'b1, a1);
    chk("b2b_gap1", 128'(a1 - a0), 128'd12);
    send(encrypt(p3), p3, 1'b1, a2);
    chk("b2b_gap2", 128'(a2 - a1), 128'd12);
    in_valid = 1'b0;
    drain();

    // Reset while round 5 is in flight
    send(CT1, PT1, 1'b0, a0);
    for (int n = 0; n < 20 && rk_idx != 4'd5; n++) @(negedge clk);
    chk("mid_rk_idx", 128'(rk_idx), 128'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_data", data_out, 128'd0);
    chk("mid_rst_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_rk_idx", 128'(rk_idx), 128'd10);
    exp_q.delete();
    acc_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 128'(in_ready), 128'd1);
    chk("post_rst_data", data_out, 128'd0);
    @(posedge clk); #1;
    send(CT1, PT1, 1'b0, a0);
    drain();

    // Round-trip through the forward reference
    for (int k = 0; k < 1000; k++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      pt  = {$urandom, $urandom, $urandom, $urandom};
      load_key(key);
      send(encrypt(pt), pt, 1'b0, a0);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
